cond_unit_pipe: RTL

- Parametrised, pipelined conditional-execution unit for the next core revision.
- Holds the architectural NZCV flag register with per-group write enables and evaluates the 4-bit condition field in the Execute stage.
- Registers the gated control strobes into the Memory stage, with stall and flush support.
- Adds a flag save stack for exception entry and return. Sits between the decoder and the E/M pipeline register.

---
 rtl/cond_pkg.sv | 41 ++++
 rtl/cond_unit_pipe_if.sv | 44 ++++
 rtl/cond_eval.sv | 42 ++++
 rtl/cond_unit_pipe.sv | 111 +++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared condition codes, flag positions and group-mask helper for the
// conditional-execution unit and its users.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Flag bit index is FLAG_W - FLAG_x, so N sits at the MSB.
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 4;

    localparam int MASK_W = 32;

    function automatic logic [MASK_W-1:0] group_mask(int flag_w, int ngroups, int g);
        int gw;
        logic [MASK_W-1:0] m;
        gw = flag_w / ngroups;
        m  = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i >= g * gw && i < (g + 1) * gw) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/cond_unit_pipe_if.sv
// Decoder-side bundle for the conditional-execution unit: Execute-stage
// controls in, condition result, flags and Memory-stage strobes out.
interface cond_unit_pipe_if #(
    parameter int FLAG_W  = 4,
    parameter int NGROUPS = 2,
    parameter int SDEPTH  = 2
);
    localparam int DEPTH_W = $clog2(SDEPTH + 1);

    logic               ex_valid;
    logic               stall;
    logic               flush;
    logic [3:0]         cond;
    logic [NGROUPS-1:0] flag_w;
    logic [FLAG_W-1:0]  alu_flag;
    logic               pcs;
    logic               reg_w;
    logic               mem_w;
    logic               no_write;
    logic               exc_entry;
    logic               exc_return;
    logic               cond_ex;
    logic [FLAG_W-1:0]  flags;
    logic               pc_src_m;
    logic               reg_write_m;
    logic               mem_write_m;
    logic [DEPTH_W-1:0] stack_depth;
    logic               stack_err;

    modport master (
        output ex_valid, stall, flush, cond, flag_w, alu_flag, pcs, reg_w,
               mem_w, no_write, exc_entry, exc_return,
        input  cond_ex, flags, pc_src_m, reg_write_m, mem_write_m,
               stack_depth, stack_err
    );

    modport slave (
        input  ex_valid, stall, flush, cond, flag_w, alu_flag, pcs, reg_w,
               mem_w, no_write, exc_entry, exc_return,
        output cond_ex, flags, pc_src_m, reg_write_m, mem_write_m,
               stack_depth, stack_err
    );

endinterface

// File: rtl/cond_eval.sv
// Pure combinational condition decoder: maps a 4-bit condition field and the
// NZCV flags to a pass/fail bit.
module cond_eval
    import cond_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_W-FLAG_N];
    assign z = flags[FLAG_W-FLAG_Z];
    assign c = flags[FLAG_W-FLAG_C];
    assign v = flags[FLAG_W-FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c & !z;
            COND_LS: cond_ex = !c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit_pipe.sv
// Conditional-execution unit: NZCV register with grouped write enables,
// E/M control register with stall/flush, and an exception flag save stack.
module cond_unit_pipe
    import cond_pkg::*;
#(
    parameter int FLAG_W  = 4,
    parameter int NGROUPS = 2,
    parameter int SDEPTH  = 2
) (
    input logic             clk,
    input logic             reset,
    cond_unit_pipe_if.slave bus
);

    localparam int DEPTH_W = $clog2(SDEPTH + 1);

    logic [FLAG_W-1:0]  flags_q;
    logic [DEPTH_W-1:0] depth_q;
    logic               err_q;
    logic               pc_src_q, reg_write_q, mem_write_q;
    logic [FLAG_W-1:0]  stack_mem [SDEPTH];

    logic               cond_ex;
    logic               live;
    logic [FLAG_W-1:0]  grp_mask [NGROUPS];
    logic [FLAG_W-1:0]  wr_mask;
    logic [FLAG_W-1:0]  top_entry;
    logic               conflict, push_req, pop_req, full, empty;

    cond_eval #(.FLAG_W(FLAG_W)) u_eval (
        .cond    (bus.cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
        localparam logic [MASK_W-1:0] GM = group_mask(FLAG_W, NGROUPS, g);
        assign grp_mask[g] = GM[FLAG_W-1:0];
    end

    always_comb begin
        wr_mask = '0;
        for (int g = 0; g < NGROUPS; g++) begin
            if (bus.flag_w[g]) wr_mask = wr_mask | grp_mask[g];
        end
    end

    always_comb begin
        top_entry = '0;
        for (int i = 0; i < SDEPTH; i++) begin
            if (int'(depth_q) - 1 == i) top_entry = stack_mem[i];
        end
    end

    // Exception entry kills the Execute instruction, so it never commits.
    assign live     = bus.ex_valid & !bus.flush & !bus.exc_entry & cond_ex;
    assign conflict = bus.exc_entry & bus.exc_return;
    assign push_req = bus.exc_entry & !bus.exc_return;
    assign pop_req  = bus.exc_return & !bus.exc_entry;
    assign full     = (depth_q == DEPTH_W'(SDEPTH));
    assign empty    = (depth_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q     <= '0;
            depth_q     <= '0;
            err_q       <= 1'b0;
            pc_src_q    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            for (int i = 0; i < SDEPTH; i++) stack_mem[i] <= '0;
        end else begin
            if (!bus.stall) begin
                pc_src_q    <= live & bus.pcs;
                reg_write_q <= live & bus.reg_w & !bus.no_write;
                mem_write_q <= live & bus.mem_w;
            end
            // Stack operations ignore stall; a pop outranks any ALU flag write.
            if (conflict) begin
                err_q <= 1'b1;
            end else if (push_req) begin
                if (full) begin
                    err_q <= 1'b1;
                end else begin
                    for (int i = 0; i < SDEPTH; i++) begin
                        if (i == int'(depth_q)) stack_mem[i] <= flags_q;
                    end
                    depth_q <= depth_q + 1'b1;
                end
            end else if (pop_req) begin
                if (empty) begin
                    err_q <= 1'b1;
                end else begin
                    flags_q <= top_entry;
                    depth_q <= depth_q - 1'b1;
                end
            end else if (live && !bus.stall) begin
                flags_q <= (flags_q & ~wr_mask) | (bus.alu_flag & wr_mask);
            end
        end
    end

    assign bus.cond_ex     = cond_ex;
    assign bus.flags       = flags_q;
    assign bus.pc_src_m    = pc_src_q;
    assign bus.reg_write_m = reg_write_q;
    assign bus.mem_write_m = mem_write_q;
    assign bus.stack_depth = depth_q;
    assign bus.stack_err   = err_q;

endmodule
